pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter register and next-PC logic for the single-cycle CPU; sits upstream of the
//  16->32 immediate extender. Fetches from a word-addressed instruction memory and hands
//  instr[15:0] to the extender. Consumes the extended immediate back as the branch offset.
//  Selects among PC+4, branch, jump and jr targets. Traps misaligned or out-of-range fetches.
// PARAMETERS
//  RESET_PC     32'h0000_3000  byte address loaded on reset; base of instruction memory
//  IMEM_ADDR_W  10             instruction memory word-address width (2^10 words)
// PORTS
//  clk          in   1    rising-edge clock
//  reset        in   1    synchronous, active-high reset
//  stall        in   1    1 = hold PC this cycle
//  Branch       in   1    current instruction is a conditional branch
//  Zero         in   1    ALU zero flag; branch taken = Branch & Zero
//  Jump         in   1    j/jal: target = {pc_plus4[31:28], instr[25:0], 2'b00}
//  Jr           in   1    jr: target = jr_target
//  jr_target    in   32   register-file rs value
//  imm_ext_32   in   32   extender output (sign/zero-extended instr[15:0])
//  imem_rdata   in   32   instruction word at imem_addr (combinational read)
//  imem_addr    out  IMEM_ADDR_W  word address = (pc - RESET_PC) >> 2
//  pc           out  32   current PC
//  pc_plus4     out  32   pc + 4 (link value for jal)
//  instr        out  32   imem_rdata when instr_valid, else 32'h0 (nop)
//  imm16        out  16   instr[15:0], to extender data_in_16
//  instr_valid  out  1    instr is a live instruction this cycle
//  fault        out  1    sticky fetch fault
// BEHAVIOUR
//  - FSM states BOOT, RUN, FAULT; all updates on rising clk.
//  - reset=1 (any state, any inputs): state<=BOOT, pc<=RESET_PC, fault<=0; overrides stall.
//  - BOOT: instr_valid=0, pc held; next cycle state<=RUN. Exactly one BOOT cycle after reset.
//  - RUN: instr_valid=1.
//    - stall=1: pc held, no fault check on next-PC.
//    - else next_pc priority Jr > Jump > (Branch&Zero) > pc_plus4.
//    - Branch target = pc_plus4 + (imm_ext_32 << 2), modulo 2^32 (wrap, no overflow flag).
//    - pc_plus4 wraps 32'hFFFF_FFFC -> 32'h0.
//  - Fault check on next_pc before commit:
//    - next_pc[1:0] != 0, or
//    - (next_pc - RESET_PC) >> 2 >= 2^IMEM_ADDR_W (unsigned; below RESET_PC also wraps out of range)
//    - on fault: pc NOT updated, state<=FAULT, fault<=1.
//  - FAULT: pc frozen, instr_valid=0, instr=0, fault=1; only reset exits.
//  - Reset values: pc=RESET_PC, pc_plus4=RESET_PC+4, imem_addr=0, instr_valid=0, instr=0,
//    imm16=0, fault=0.
//  - Simultaneous Jr and Jump: Jr wins. Branch with Zero=0: pc_plus4, even if imm invalid.
//  - Latency: pc, imem_addr, pc_plus4 are registered/derived from pc.
//  - instr, imm16 and next_pc are combinational within the cycle (single-cycle datapath).
// TESTING
//  1. reset 2 cycles, release -> pc=0x3000 and instr_valid=0 for 1 cycle; then pc 0x3004, 0x3008...
//  2. pc=0x3010, Branch=1, Zero=1, imm_ext_32=32'hFFFF_FFFF -> next pc=0x3010; Zero=0 -> 0x3014.
//  3. pc=0x3000, Jump=1, instr=32'h0800_0C10 -> next pc=0x0000_3040.
//  4. Jr=1 & Jump=1, jr_target=0x3100 -> pc=0x3100. Jr=1, jr_target=0x3102 -> fault=1, pc holds.
//     Then instr_valid=0 and pc frozen despite stimulus.
//  5. Branch to 0x4000 (range ends 0x3FFC) -> fault=1, pc holds. Assert reset -> pc=0x3000,
//     fault=0, BOOT then RUN.
//  6. stall=1 for 3 cycles with Branch&Zero=1 -> pc unchanged; stall=0 -> branch taken once.

Source files
------------

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: control, branch/jump operands, instruction memory and PC outputs of the fetch unit
interface pc_fetch_if #(parameter int IMEM_ADDR_W = 10);
  logic                   stall;
  logic                   Branch;
  logic                   Zero;
  logic                   Jump;
  logic                   Jr;
  logic [31:0]            jr_target;
  logic [31:0]            imm_ext_32;
  logic [31:0]            imem_rdata;
  logic [IMEM_ADDR_W-1:0] imem_addr;
  logic [31:0]            pc;
  logic [31:0]            pc_plus4;
  logic [31:0]            instr;
  logic [15:0]            imm16;
  logic                   instr_valid;
  logic                   fault;
  modport master (
    output stall, Branch, Zero, Jump, Jr, jr_target, imm_ext_32, imem_rdata,
    input  imem_addr, pc, pc_plus4, instr, imm16, instr_valid, fault
  );
  modport slave (
    input  stall, Branch, Zero, Jump, Jr, jr_target, imm_ext_32, imem_rdata,
    output imem_addr, pc, pc_plus4, instr, imm16, instr_valid, fault
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, next-PC select and fetch trap for the single-cycle CPU
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int          IMEM_ADDR_W = 10
) (
  input logic         clk,
  input logic         reset,
  pc_fetch_if.slave   bus
);
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
  localparam logic [31:0] IMEM_BYTES = 32'd4 << IMEM_ADDR_W;
  state_t      state, state_n;
  logic [31:0] pc, next_pc, br_target, jmp_target;
  logic        advance, bad;
  always_ff @(posedge clk) begin
    state <= reset ? BOOT : state_n;
    pc    <= reset ? RESET_PC : (advance && !bad) ? next_pc : pc;
  end
  always_comb begin
    br_target  = bus.pc_plus4 + (bus.imm_ext_32 << 2);
    jmp_target = {bus.pc_plus4[31:28], bus.instr[25:0], 2'b00};
    next_pc    = bus.Jr ? bus.jr_target : bus.Jump ? jmp_target :
                 (bus.Branch && bus.Zero) ? br_target : bus.pc_plus4;
    // Unsigned offset: targets below RESET_PC wrap high and land out of range.
    bad        = |next_pc[1:0] || ((next_pc - RESET_PC) >= IMEM_BYTES);
    advance    = state == RUN && !bus.stall;
    state_n    = state == BOOT ? RUN :
                 state == RUN  ? ((advance && bad) ? FAULT : RUN) : FAULT;
  end
  always_comb begin
    bus.pc          = pc;
    bus.pc_plus4    = pc + 32'd4;
    bus.imem_addr   = IMEM_ADDR_W'((pc - RESET_PC) >> 2);
    bus.instr_valid = state == RUN;
    bus.instr       = bus.instr_valid ? bus.imem_rdata : 32'h0;
    bus.imm16       = bus.instr[15:0];
    bus.fault       = state == FAULT;
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed checks of reset, sequencing, branch/jump/jr, faults and stall
module tb_pc_fetch_unit;
  logic clk = 0;
  logic reset;
  int checks = 0;
  int errors = 0;
  pc_fetch_if #(.IMEM_ADDR_W(10)) bus ();
  pc_fetch_unit #(.RESET_PC(32'h0000_3000), .IMEM_ADDR_W(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic restart();
    reset = 1;
    tick();
    reset = 0;
    tick();
  endtask
  initial begin
    reset = 1;
    bus.stall = 0; bus.Branch = 0; bus.Zero = 0; bus.Jump = 0; bus.Jr = 0;
    bus.jr_target = 0; bus.imm_ext_32 = 0; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    tick();
    check("rst_pc", bus.pc, 32'h3000);
    check("rst_pc4", bus.pc_plus4, 32'h3004);
    check("rst_addr", 32'(bus.imem_addr), 0);
    check("rst_valid", 32'(bus.instr_valid), 0);
    check("rst_instr", bus.instr, 0);
    check("rst_imm16", 32'(bus.imm16), 0);
    check("rst_fault", 32'(bus.fault), 0);
    reset = 0;
    #1;
    check("boot_valid", 32'(bus.instr_valid), 0);
    tick();
    check("run_pc", bus.pc, 32'h3000);
    check("run_valid", 32'(bus.instr_valid), 1);
    check("run_instr", bus.instr, 32'hDEAD_BEEF);
    check("run_imm16", 32'(bus.imm16), 32'hBEEF);
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("seq_pc", bus.pc, 32'h3000 + 32'(4 * i));
      check("seq_addr", 32'(bus.imem_addr), 32'(i));
    end
    bus.Branch = 1; bus.Zero = 1; bus.imm_ext_32 = 32'hFFFF_FFFF;
    tick();
    check("br_back", bus.pc, 32'h3010);
    bus.Zero = 0;
    tick();
    check("br_nt", bus.pc, 32'h3014);
    bus.Branch = 0;
    restart();
    check("j_start", bus.pc, 32'h3000);
    bus.Jump = 1; bus.imem_rdata = 32'h0800_0C10;
    #1;
    check("j_imm16", 32'(bus.imm16), 32'h0C10);
    tick();
    check("j_pc", bus.pc, 32'h3040);
    bus.Jr = 1; bus.jr_target = 32'h3100;
    tick();
    check("jr_wins", bus.pc, 32'h3100);
    bus.Jump = 0; bus.jr_target = 32'h3102;
    tick();
    check("jr_mis_fault", 32'(bus.fault), 1);
    check("jr_mis_pc", bus.pc, 32'h3100);
    check("fault_valid", 32'(bus.instr_valid), 0);
    check("fault_instr", bus.instr, 0);
    bus.Jr = 0; bus.Branch = 1; bus.Zero = 1; bus.imm_ext_32 = 32'h4;
    tick();
    tick();
    check("fault_frozen", bus.pc, 32'h3100);
    check("fault_sticky", 32'(bus.fault), 1);
    bus.Branch = 0; bus.Zero = 0; bus.imm_ext_32 = 0;
    reset = 1;
    tick();
    check("rerst_pc", bus.pc, 32'h3000);
    check("rerst_fault", 32'(bus.fault), 0);
    reset = 0;
    #1;
    check("rerst_boot", 32'(bus.instr_valid), 0);
    tick();
    check("rerst_run", 32'(bus.instr_valid), 1);
    bus.Jr = 1; bus.jr_target = 32'h3FFC;
    tick();
    check("top_pc", bus.pc, 32'h3FFC);
    check("top_addr", 32'(bus.imem_addr), 32'h3FF);
    check("top_pc4", bus.pc_plus4, 32'h4000);
    bus.Jr = 0; bus.Branch = 1; bus.Zero = 1;
    tick();
    check("oor_fault", 32'(bus.fault), 1);
    check("oor_pc", bus.pc, 32'h3FFC);
    bus.Branch = 0; bus.Zero = 0;
    restart();
    bus.stall = 1; bus.Branch = 1; bus.Zero = 1; bus.imm_ext_32 = 32'h4;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.pc, 32'h3000);
    end
    bus.stall = 0;
    tick();
    check("stall_br", bus.pc, 32'h3014);
    bus.Branch = 0; bus.Zero = 0;
    tick();
    check("after_br", bus.pc, 32'h3018);
    restart();
    bus.Jr = 1; bus.jr_target = 32'h2FFC;
    tick();
    check("below_fault", 32'(bus.fault), 1);
    check("below_pc", bus.pc, 32'h3000);
    bus.Jr = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
